// File: rtl/sfa_bif_pkg.sv
// Shared types and helpers for the SFA BRAM/stream bridge.
package sfa_bif_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  // Left shift that turns an element index into a byte address.
  function automatic int byteShift(input int dataW);
    return $clog2(dataW / 8);
  endfunction

endpackage

// File: rtl/sfa_skid_buf2.sv
// Two-entry valid/ready buffer on the read path; the upstream side is
// credit-limited by the caller, so a push never targets a full buffer.
module sfa_skid_buf2 #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  output logic [1:0]        o_count
);

  logic [DATA_W-1:0] r_data0;
  logic [DATA_W-1:0] r_data1;
  logic [1:0]        r_count;
  logic              w_pop;

  assign w_pop   = (r_count != 2'd0) & i_ready;
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_data0;
  assign o_count = r_count;

  // r_data0 is always the head; r_data1 only holds data when two entries are live.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= 2'd0;
    end else begin
      case ({i_valid, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_data0 <= i_data;
          else                 r_data1 <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_data0 <= r_data1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd2) begin
            r_data0 <= r_data1;
            r_data1 <= i_data;
          end else begin
            r_data0 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sfa_bif_stream.sv
// BRAM <-> AXI-Stream bridge for an SFA slot (MODE 0 read, MODE 1 write).
// Define SFA_BIF_STREAM_TLAST_EN to add mBIF_tlast / sBIF_tlast.
module sfa_bif_stream
  import sfa_bif_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int IDX_W       = 24,
  parameter int CNT_W       = 24,
  parameter int BRAM_ADDR_W = 32
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  output logic                   bram_clk,
  output logic                   bram_rst,
  output logic                   bram_en,
  output logic [DATA_W/8-1:0]    bram_we,
  output logic [BRAM_ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0]      bram_din,
  input  logic [DATA_W-1:0]      bram_dout,
  output logic                   sBIF_tready,
  input  logic                   sBIF_tvalid,
  input  logic [DATA_W-1:0]      sBIF_tdata,
  input  logic                   mBIF_tready,
  output logic                   mBIF_tvalid,
  output logic [DATA_W-1:0]      mBIF_tdata,
  input  logic                   ap_start,
  output logic                   ap_done,
  output logic                   ap_idle,
  input  logic                   MODE,
  input  logic [IDX_W-1:0]       INDEX,
  input  logic [CNT_W-1:0]       SIZE,
  input  logic [IDX_W-1:0]       STRIDE
`ifdef SFA_BIF_STREAM_TLAST_EN
  ,
  output logic                   mBIF_tlast,
  input  logic                   sBIF_tlast
`endif
);

  localparam int SHIFT = byteShift(DATA_W);

  state_t r_state;
  state_t w_nextState;

  logic [IDX_W-1:0]       r_elemAddr;
  logic [IDX_W-1:0]       r_stride;
  logic [CNT_W-1:0]       r_size;
  logic [CNT_W-1:0]       r_issueCnt;
  logic [CNT_W-1:0]       r_beatCnt;
  logic                   r_inflight;
  logic                   w_issue;
  logic                   w_rdBeat;
  logic                   w_wrBeat;
  logic                   w_lastBeat;
  logic                   w_wrFinal;
  logic                   w_bufValid;
  logic [1:0]             w_bufCount;
  logic [2:0]             w_outstanding;
  logic [IDX_W+SHIFT-1:0] w_byteAddr;

  assign bram_clk = ACLK;
  assign bram_rst = ARESET;
  assign bram_din = sBIF_tdata;

  assign w_byteAddr = (IDX_W + SHIFT)'(r_elemAddr) << SHIFT;
  assign bram_addr  = BRAM_ADDR_W'(w_byteAddr);

  assign w_lastBeat  = (r_beatCnt == r_size - CNT_W'(1));
  assign w_rdBeat    = (r_state == RD) & w_bufValid & mBIF_tready;
  assign sBIF_tready = (r_state == WR) & (r_beatCnt < r_size);
  assign w_wrBeat    = sBIF_tready & sBIF_tvalid;

  // A beat leaving this cycle frees its slot, so reads can issue every cycle.
  assign w_outstanding = {1'b0, w_bufCount} + {2'b00, r_inflight} - {2'b00, w_rdBeat};
  assign w_issue       = (r_state == RD) & (r_issueCnt < r_size) & (w_outstanding < 3'd2);

  assign bram_en     = w_issue | w_wrBeat;
  assign bram_we     = {(DATA_W/8){w_wrBeat}};
  assign mBIF_tvalid = w_bufValid;
  assign ap_idle     = (r_state == IDLE);
  assign ap_done     = (r_state == DONE);

`ifdef SFA_BIF_STREAM_TLAST_EN
  assign mBIF_tlast = (r_state == RD) & w_bufValid & w_lastBeat;
  assign w_wrFinal  = w_lastBeat | sBIF_tlast;
`else
  assign w_wrFinal  = w_lastBeat;
`endif

  sfa_skid_buf2 #(
    .DATA_W(DATA_W)
  ) u_skid (
    .i_clk  (ACLK),
    .i_reset(ARESET),
    .i_valid(r_inflight),
    .i_data (bram_dout),
    .o_valid(w_bufValid),
    .o_data (mBIF_tdata),
    .i_ready(mBIF_tready),
    .o_count(w_bufCount)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (ap_start) begin
          if (SIZE == '0)              w_nextState = DONE;
          else if (MODE == MODE_WRITE) w_nextState = WR;
          else                         w_nextState = RD;
        end
      end
      RD:      if (w_rdBeat && w_lastBeat) w_nextState = DONE;
      WR:      if (w_wrBeat && w_wrFinal)  w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Shadow copies of the request so the slot controller may change inputs after start.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_inflight <= 1'b0;
      r_elemAddr <= '0;
      r_stride   <= '0;
      r_size     <= '0;
      r_issueCnt <= '0;
      r_beatCnt  <= '0;
    end else begin
      r_inflight <= w_issue;
      if ((r_state == IDLE) && ap_start) begin
        r_elemAddr <= INDEX;
        r_stride   <= STRIDE;
        r_size     <= SIZE;
        r_issueCnt <= '0;
        r_beatCnt  <= '0;
      end else begin
        if (w_issue || w_wrBeat) r_elemAddr <= r_elemAddr + r_stride;
        if (w_issue)             r_issueCnt <= r_issueCnt + CNT_W'(1);
        if (w_rdBeat || w_wrBeat) r_beatCnt <= r_beatCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sfa_bif_stream.sv
// Scoreboard bench for sfa_bif_stream with a registered-read BRAM model.
// Covers SFA_BIF_STREAM_TLAST_EN cases when that macro is defined.
module tb_sfa_bif_stream;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        ARESET;
  logic        bram_clk;
  logic        bram_rst;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [31:0] bram_addr;
  logic [31:0] bram_din;
  logic [31:0] bram_dout;
  logic        sBIF_tready;
  logic        sBIF_tvalid;
  logic [31:0] sBIF_tdata;
  logic        mBIF_tready;
  logic        mBIF_tvalid;
  logic [31:0] mBIF_tdata;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        MODE;
  logic [23:0] INDEX;
  logic [23:0] SIZE;
  logic [23:0] STRIDE;
`ifdef SFA_BIF_STREAM_TLAST_EN
  logic        mBIF_tlast;
  logic        sBIF_tlast;
`endif

  logic [31:0] mem [0:255];

  beat_t expBeats[$];
  logic [31:0] expRdAddr[$];
  wr_t expWr[$];

  int checks = 0;
  int errors = 0;
  int edgeCnt = 0;
  int startEdge = 0;
  int firstValidEdge = -1;
  int lastBeatEdge = 0;
  int doneEdge = 0;
  int doneCount = 0;
  int beatsSeen = 0;
  int bramEnCount = 0;
  int hsCount = 0;
  int outst = 0;
  logic prevHeld = 1'b0;
  logic [31:0] prevData = '0;
  beat_t monBeat;
  wr_t monWr;
  logic [31:0] monAddr;
  logic wrHs;
  logic rdIssue;
  logic rdHs;

  sfa_bif_stream dut (
    .ACLK       (clk),
    .ARESET     (ARESET),
    .bram_clk   (bram_clk),
    .bram_rst   (bram_rst),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .bram_dout  (bram_dout),
    .sBIF_tready(sBIF_tready),
    .sBIF_tvalid(sBIF_tvalid),
    .sBIF_tdata (sBIF_tdata),
    .mBIF_tready(mBIF_tready),
    .mBIF_tvalid(mBIF_tvalid),
    .mBIF_tdata (mBIF_tdata),
    .ap_start   (ap_start),
    .ap_done    (ap_done),
    .ap_idle    (ap_idle),
    .MODE       (MODE),
    .INDEX      (INDEX),
    .SIZE       (SIZE),
    .STRIDE     (STRIDE)
`ifdef SFA_BIF_STREAM_TLAST_EN
    ,
    .mBIF_tlast (mBIF_tlast),
    .sBIF_tlast (sBIF_tlast)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt++;

  // BRAM model: one-cycle registered read, write-through on we.
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we != 4'h0) mem[bram_addr[9:2]] = bram_din;
      else                 bram_dout <= mem[bram_addr[9:2]];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, required);
    end
  endtask

  task automatic missing(input string name, input logic [31:0] actual);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %0h required nothing", name, actual);
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on every DUT event.
  always @(negedge clk) begin
    if (ARESET) begin
      prevHeld = 1'b0;
    end else begin
      if (prevHeld) begin
        checkOutput("hold valid", mBIF_tvalid, 1);
        checkOutput("hold data", mBIF_tdata, prevData);
      end
      prevHeld = mBIF_tvalid && !mBIF_tready;
      prevData = mBIF_tdata;
      if (mBIF_tvalid && firstValidEdge < 0) firstValidEdge = edgeCnt;

      rdHs = mBIF_tvalid && mBIF_tready;
      if (rdHs) begin
        beatsSeen++;
        hsCount++;
        lastBeatEdge = edgeCnt;
        if (expBeats.size() == 0) missing("unexpected beat", mBIF_tdata);
        else begin
          monBeat = expBeats.pop_front();
          checkOutput("beat data", mBIF_tdata, monBeat.data);
`ifdef SFA_BIF_STREAM_TLAST_EN
          checkOutput("beat tlast", mBIF_tlast, monBeat.last);
`endif
        end
      end

      if (bram_en) bramEnCount++;
      rdIssue = bram_en && (bram_we == 4'h0);
      outst = outst + (rdIssue ? 1 : 0) - (rdHs ? 1 : 0);
      if (rdIssue) begin
        checkOutput("outstanding le 2", outst <= 2, 1);
        if (expRdAddr.size() == 0) missing("unexpected read", bram_addr);
        else begin
          monAddr = expRdAddr.pop_front();
          checkOutput("read addr", bram_addr, monAddr);
        end
      end

      wrHs = sBIF_tvalid && sBIF_tready;
      if (wrHs) hsCount++;
      if (wrHs || bram_we != 4'h0)
        checkOutput("we vs handshake", {bram_en, bram_we}, wrHs ? 5'h1F : 5'h00);
      if (bram_en && bram_we != 4'h0) begin
        if (expWr.size() == 0) missing("unexpected write", bram_addr);
        else begin
          monWr = expWr.pop_front();
          checkOutput("write addr", bram_addr, monWr.addr);
          checkOutput("write data", bram_din, monWr.data);
        end
      end

      if (ap_done) begin
        doneCount++;
        doneEdge = edgeCnt;
      end
    end
  end

  task automatic applyStimulus(input logic mode, input int index, input int size, input int stride);
    @(posedge clk); #1;
    MODE     = mode;
    INDEX    = 24'(index);
    SIZE     = 24'(size);
    STRIDE   = 24'(stride);
    ap_start = 1'b1;
    @(posedge clk); #1;
    startEdge = edgeCnt;
    ap_start = 1'b0;
    MODE     = ~mode;
    INDEX    = '1;
    SIZE     = '1;
    STRIDE   = '1;
  endtask

  task automatic waitDone(input int d0, input int budget, input string name);
    for (int i = 0; i < budget && doneCount == d0; i++) begin
      @(posedge clk); #1;
    end
    checkOutput(name, doneCount - d0, 1);
  endtask

  task automatic sendBeat(input logic [31:0] data, input int gap, input logic last);
    repeat (gap) begin
      @(posedge clk); #1;
    end
    sBIF_tvalid = 1'b1;
    sBIF_tdata  = data;
`ifdef SFA_BIF_STREAM_TLAST_EN
    sBIF_tlast  = last;
`endif
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sBIF_tready) break;
    end
    checkOutput("write accepted", sBIF_tready, 1);
    @(posedge clk); #1;
    sBIF_tvalid = 1'b0;
`ifdef SFA_BIF_STREAM_TLAST_EN
    sBIF_tlast  = 1'b0;
`else
    if (last) sBIF_tdata = '0;
`endif
  endtask

  task automatic pushRead(input logic [31:0] data, input logic [31:0] addr, input logic last);
    beat_t b;
    b.data = data;
    b.last = last;
    expBeats.push_back(b);
    expRdAddr.push_back(addr);
  endtask

  task automatic pushWrite(input logic [31:0] addr, input logic [31:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    expWr.push_back(w);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int d0, e0, h0, b0;
    int t1Data[4] = '{32, 48, 64, 80};
    int t1Addr[4] = '{8, 12, 16, 20};
    int t2Data[6] = '{320, 352, 384, 416, 448, 480};
    int t2Addr[6] = '{80, 88, 96, 104, 112, 120};
    int t5Data[5] = '{0, 16, 32, 48, 64};
    int t6Data[2] = '{112, 192};
    int t6Addr[2] = '{28, 48};
    logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 256; i++) mem[i] = 32'(i * 16);
    ARESET = 1'b1;
    ap_start = 1'b0;
    MODE = 1'b0;
    INDEX = '0;
    SIZE = '0;
    STRIDE = '0;
    sBIF_tvalid = 1'b0;
    sBIF_tdata = '0;
    mBIF_tready = 1'b0;
`ifdef SFA_BIF_STREAM_TLAST_EN
    sBIF_tlast = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    ARESET = 1'b0;
    checkOutput("reset ap_done", ap_done, 0);
    checkOutput("reset ap_idle", ap_idle, 1);
    checkOutput("reset mBIF_tvalid", mBIF_tvalid, 0);
    checkOutput("reset sBIF_tready", sBIF_tready, 0);
    checkOutput("reset bram_en", bram_en, 0);
    checkOutput("reset bram_we", bram_we, 0);

    $display("[TB] read INDEX=2 SIZE=4 STRIDE=1");
    mBIF_tready = 1'b1;
    for (int i = 0; i < 4; i++) pushRead(32'(t1Data[i]), 32'(t1Addr[i]), i == 3);
    firstValidEdge = -1;
    d0 = doneCount;
    applyStimulus(1'b0, 2, 4, 1);
    waitDone(d0, 50, "rd1 done");
    checkOutput("rd1 first valid latency", firstValidEdge - startEdge, 2);
    checkOutput("rd1 consecutive beats", lastBeatEdge - firstValidEdge, 3);
    checkOutput("rd1 done after last beat", doneEdge - lastBeatEdge, 1);
    checkOutput("rd1 idle", ap_idle, 1);
    checkOutput("rd1 beats drained", expBeats.size(), 0);
    checkOutput("rd1 addrs drained", expRdAddr.size(), 0);

    $display("[TB] read SIZE=6 with tready 1-0-0-1");
    for (int i = 0; i < 6; i++) pushRead(32'(t2Data[i]), 32'(t2Addr[i]), i == 5);
    d0 = doneCount;
    applyStimulus(1'b0, 20, 6, 2);
    for (int k = 0; k < 100 && doneCount == d0; k++) begin
      @(posedge clk); #1;
      mBIF_tready = pat[k % 4];
    end
    mBIF_tready = 1'b1;
    waitDone(d0, 5, "rd2 done");
    checkOutput("rd2 beats drained", expBeats.size(), 0);
    checkOutput("rd2 addrs drained", expRdAddr.size(), 0);

    $display("[TB] write INDEX=10 SIZE=3 STRIDE=3 gapped");
    pushWrite(32'd40, 32'hA5A5_0001);
    pushWrite(32'd52, 32'hA5A5_0002);
    pushWrite(32'd64, 32'hA5A5_0003);
    d0 = doneCount;
    e0 = bramEnCount;
    applyStimulus(1'b1, 10, 3, 3);
    sendBeat(32'hA5A5_0001, 0, 1'b0);
    sendBeat(32'hA5A5_0002, 2, 1'b0);
    sendBeat(32'hA5A5_0003, 1, 1'b0);
    waitDone(d0, 20, "wr done");
    checkOutput("wr bram_en count", bramEnCount - e0, 3);
    checkOutput("wr mem10", mem[10], 32'hA5A5_0001);
    checkOutput("wr mem13", mem[13], 32'hA5A5_0002);
    checkOutput("wr mem16", mem[16], 32'hA5A5_0003);
    checkOutput("wr drained", expWr.size(), 0);

    for (int m = 0; m < 2; m++) begin
      $display("[TB] SIZE=0 mode %0d", m);
      d0 = doneCount;
      e0 = bramEnCount;
      h0 = hsCount;
      applyStimulus(m[0], 5, 0, 1);
      @(posedge clk); #1;
      checkOutput("size0 done count", doneCount - d0, 1);
      checkOutput("size0 done timing", doneEdge - startEdge, 0);
      checkOutput("size0 no bram_en", bramEnCount - e0, 0);
      checkOutput("size0 no handshake", hsCount - h0, 0);
      checkOutput("size0 idle", ap_idle, 1);
    end

    $display("[TB] reset mid-read");
    for (int i = 0; i < 5; i++) pushRead(32'(t5Data[i]), 32'(i * 4), i == 4);
    b0 = beatsSeen;
    d0 = doneCount;
    applyStimulus(1'b0, 0, 5, 1);
    for (int i = 0; i < 30 && (beatsSeen - b0) < 2; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("rst beats before reset", beatsSeen - b0, 2);
    ARESET = 1'b1;
    mBIF_tready = 1'b0;
    @(posedge clk); #1;
    ARESET = 1'b0;
    checkOutput("rst mBIF_tvalid", mBIF_tvalid, 0);
    checkOutput("rst ap_idle", ap_idle, 1);
    checkOutput("rst ap_done", ap_done, 0);
    expBeats.delete();
    expRdAddr.delete();
    outst = 0;
    mBIF_tready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("rst no done pulse", doneCount - d0, 0);
    checkOutput("rst still idle", ap_idle, 1);

    for (int i = 0; i < 2; i++) pushRead(32'(t6Data[i]), 32'(t6Addr[i]), i == 1);
    d0 = doneCount;
    applyStimulus(1'b0, 7, 2, 5);
    waitDone(d0, 30, "post-reset done");
    checkOutput("post-reset drained", expBeats.size(), 0);

`ifdef SFA_BIF_STREAM_TLAST_EN
    $display("[TB] tlast write SIZE=8 ends after beat 3");
    pushWrite(32'd160, 32'h0000_BEE0);
    pushWrite(32'd164, 32'h0000_BEE1);
    pushWrite(32'd168, 32'h0000_BEE2);
    d0 = doneCount;
    e0 = bramEnCount;
    applyStimulus(1'b1, 40, 8, 1);
    sendBeat(32'h0000_BEE0, 0, 1'b0);
    sendBeat(32'h0000_BEE1, 0, 1'b0);
    sendBeat(32'h0000_BEE2, 1, 1'b1);
    waitDone(d0, 10, "tlast wr done");
    checkOutput("tlast wr count", bramEnCount - e0, 3);
    checkOutput("tlast wr drained", expWr.size(), 0);

    $display("[TB] tlast read SIZE=4");
    pushRead(32'h0000_BEE0, 32'd160, 1'b0);
    pushRead(32'h0000_BEE1, 32'd164, 1'b0);
    pushRead(32'h0000_BEE2, 32'd168, 1'b0);
    pushRead(32'd688, 32'd172, 1'b1);
    d0 = doneCount;
    applyStimulus(1'b0, 40, 4, 1);
    waitDone(d0, 30, "tlast rd done");
    checkOutput("tlast rd drained", expBeats.size(), 0);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sfa_bif_stream.md
Name: sfa_bif_stream

Overview:
- Parametrised BRAM-to-AXI-Stream bridge for SFA accelerator slots.
- MODE=0 (read): streams SIZE words from BRAM out on mBIF. MODE=1 (write): captures SIZE words from sBIF into BRAM.
- Strided element addressing, pipelined BRAM reads behind a 2-entry skid buffer, 1 beat/cycle sustained in both modes.
- Sits between the slot's local BRAM port and the SFA stream switch; ap_* handshake driven by the slot controller.

Parameters:
- DATA_W, 32, stream/BRAM data width; power of two, >= 8.
- IDX_W, 24, width of INDEX, STRIDE and the internal element-address register.
- CNT_W, 24, width of SIZE and the beat counters.
- BRAM_ADDR_W, 32, width of bram_addr (byte address).

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- bram_clk  out  1  equals ACLK.
- bram_rst  out  1  equals ARESET.
- bram_en  out  1  BRAM enable.
- bram_we  out  DATA_W/8  byte write enables.
- bram_addr  out  BRAM_ADDR_W  byte address = elem_addr << log2(DATA_W/8), zero-extended/truncated.
- bram_din  out  DATA_W  equals sBIF_tdata.
- bram_dout  in  DATA_W  read data; valid 1 cycle after an enabled read.
- sBIF_tready  out  1  slave stream ready.
- sBIF_tvalid  in  1  slave stream valid.
- sBIF_tdata  in  DATA_W  slave stream data.
- mBIF_tready  in  1  master stream ready.
- mBIF_tvalid  out  1  master stream valid.
- mBIF_tdata  out  DATA_W  master stream data.
- ap_start  in  1  start request; sampled in IDLE only.
- ap_done  out  1  one-cycle registered completion pulse.
- ap_idle  out  1  high in IDLE.
- MODE  in  1  0 = BRAM->stream, 1 = stream->BRAM.
- INDEX  in  IDX_W  first element address.
- SIZE  in  CNT_W  number of beats.
- STRIDE  in  IDX_W  element increment per beat.

Behaviour:
- Clock and reset: one clock ACLK; synchronous active-high reset ARESET.
- Reset: state IDLE; skid buffer emptied; in-flight read squashed.
  - Registered outputs after reset: ap_done=0, ap_idle=1, mBIF_tvalid=0, sBIF_tready=0, bram_en=0, bram_we=0.
  - Reset mid-operation aborts without an ap_done pulse.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - On ap_start=1, latch MODE, INDEX, SIZE, STRIDE into shadow registers; the inputs may change afterwards.
  - Load elem_addr=INDEX, issue_cnt=0, beat_cnt=0.
  - SIZE==0 -> DONE. Otherwise MODE=0 -> RD, MODE=1 -> WR.
- RD:
  - Issue a read (bram_en=1, we=0) when issue_cnt<SIZE and (buffer occupancy + reads in flight) < 2.
  - Each issue: elem_addr += STRIDE, wrapping modulo 2^IDX_W; issue_cnt += 1.
  - Returned bram_dout is written into the 2-entry skid buffer one cycle after issue.
  - mBIF_tvalid = buffer not empty; mBIF_tdata = buffer head.
  - Buffer pop and push may happen in the same cycle.
  - beat_cnt increments on each mBIF_tvalid & mBIF_tready.
  - When the final beat is accepted -> DONE.
- RD latency: ap_start accepted at cycle 0 -> first read issued cycle 1 -> mBIF_tvalid high cycle 2. With tready held high, beats follow on consecutive cycles.
- WR:
  - sBIF_tready=1 while beat_cnt<SIZE.
  - On each sBIF_tvalid & sBIF_tready, in the same cycle: bram_en=1, bram_we=all ones, bram_addr from elem_addr, bram_din=sBIF_tdata.
  - Same edge: elem_addr += STRIDE (wrapping), beat_cnt += 1.
  - sBIF_tready is deasserted in the cycle after the final beat; that cycle -> DONE.
- DONE: ap_done=1 for exactly one cycle, then IDLE.
- ap_idle = (state==IDLE). ap_start in any other state is ignored.
- STRIDE=0 is legal: every beat uses address INDEX.
- mBIF_tvalid, once high, stays high with stable tdata until accepted.

Optional Feature:
- Macro: SFA_BIF_STREAM_TLAST_EN.
- Defined:
  - Adds output mBIF_tlast (1), high with the final beat of a read transfer.
  - Adds input sBIF_tlast (1). In WR, sBIF_tlast accepted before SIZE beats ends the transfer early: that beat is written, then DONE.
  - sBIF_tlast on or after the SIZE-th beat is ignored.
- Undefined: neither port exists; transfers always run exactly SIZE beats.

Decomposition:
- Package sfa_bif_pkg: state enum (IDLE, RD, WR, DONE), MODE_READ/MODE_WRITE constants, byte-shift function clog2(DATA_W/8).
- One sub-module: sfa_skid_buf2 (2-entry valid/ready buffer, parametrised by DATA_W) for the read path.

Test Plan:
- Read, DATA_W=32, INDEX=2, SIZE=4, STRIDE=1, tready=1, BRAM[i]=i*16 -> tdata 32,48,64,80 on consecutive cycles from cycle 2; bram_addr 8,12,16,20; ap_done pulse once, 1 cycle after the last beat.
- Read, SIZE=6, tready toggled 1-0-0-1 pattern -> no lost or duplicated beats; tdata held stable while tready=0; at most 2 reads outstanding.
- Write, INDEX=10, SIZE=3, STRIDE=3, tvalid gapped -> BRAM[10], [13], [16] written with the beats in order; we=4'hF only on handshake cycles.
- SIZE=0 with ap_start (either MODE) -> no bram_en, no stream handshake, ap_done high 1 cycle after start, then ap_idle=1.
- ARESET asserted mid-read after 2 of 5 beats -> next cycle: mBIF_tvalid=0, ap_idle=1, no ap_done. A new transfer then runs clean.
- With SFA_BIF_STREAM_TLAST_EN defined, write SIZE=8 with sBIF_tlast on beat 3 -> 3 BRAM writes, then ap_done; read SIZE=4 -> mBIF_tlast only on beat 4.
